// File: rtl/led_pkg.sv
// Shared LED sequencer definitions: mode encodings, chaser state enum and
// the mode decode helper. Used by the chaser and by the legacy LED modules.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chaser_state_e;

    // The reserved encoding 3 falls back to LEFT.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_RIGHT;
            2'd2:    m = MODE_BOUNCE;
            default: m = MODE_LEFT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/led_chaser_n_if.sv
// Control/status bundle between the LED driver FSM (master) and the chaser (slave).
interface led_chaser_n_if #(
    parameter int N_LEDS = 18,
    parameter int DIV_W  = 8,
    parameter int PASS_W = 4
) ();
    logic              run;
    logic              step_en;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  step_div;
    logic [PASS_W-1:0] passes;
    logic [N_LEDS-1:0] out;
    logic              busy;
    logic              pass_pulse;
    logic              done;

    modport master (
        output run, step_en, mode, step_div, passes,
        input  out, busy, pass_pulse, done
    );

    modport slave (
        input  run, step_en, mode, step_div, passes,
        output out, busy, pass_pulse, done
    );
endinterface

// File: rtl/led_step_prescaler.sv
// Step prescaler: ticks on every (step_div+1)-th enabled clock. A step_div
// lowered below the running count lets the counter wrap through all-ones.
module led_step_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             async_rs_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] step_div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_r;

    assign tick = enable && (cnt_r == step_div);

    // Prescaler count: cleared, reloaded on tick, otherwise counts while enabled.
    always_ff @(posedge clk or negedge async_rs_n) begin
        if (!async_rs_n) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (tick) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + DIV_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/led_chaser_n.sv
// Parametrised LED-window chaser: a WIN-wide lit block steps across an
// N_LEDS bar in LEFT/RIGHT/BOUNCE mode with pass counting and a done level.
module led_chaser_n
    import led_pkg::*;
#(
    parameter int N_LEDS = 18,
    parameter int WIN    = 3,
    parameter int DIV_W  = 8,
    parameter int PASS_W = 4
) (
    input  logic           clk,
    input  logic           async_rs_n,
    led_chaser_n_if.slave  bus
);
    localparam int POS_W = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0] MAXP     = POS_W'(N_LEDS - WIN);
    localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};

    chaser_state_e     state_r, state_s;
    mode_e             mode_r, mode_s;
    logic [PASS_W-1:0] passes_r, passes_s;
    logic [PASS_W-1:0] pass_cnt_r, pass_cnt_s, pass_inc_s;
    logic [POS_W-1:0]  pos_r, pos_s, step_pos_s;
    logic              dir_up_r, dir_up_s, step_dir_s, wrap_s;
    logic [N_LEDS-1:0] out_r, out_s;
    logic              pulse_r, pulse_s;
    logic              busy_r, done_r;
    logic              tick_s, presc_clear_s, presc_en_s;

    function automatic logic [N_LEDS-1:0] win_pattern(input logic [POS_W-1:0] p);
        logic [N_LEDS-1:0] m;
        m = {N_LEDS{1'b0}};
        for (int i = 0; i < N_LEDS; i++) begin
            if ((i >= int'(p)) && (i < int'(p) + WIN)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic logic [POS_W-1:0] home_pos(input mode_e m);
        return (m == MODE_RIGHT) ? MAXP : POS_ZERO;
    endfunction

    assign presc_clear_s = (state_r == ST_IDLE);
    assign presc_en_s    = (state_r == ST_RUN) && bus.step_en;
    assign pass_inc_s    = pass_cnt_r + PASS_W'(1);

    led_step_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk        (clk),
        .async_rs_n (async_rs_n),
        .clear      (presc_clear_s),
        .enable     (presc_en_s),
        .step_div   (bus.step_div),
        .tick       (tick_s)
    );

    // Position/direction the next tick would produce, plus end-of-pass detect.
    always_comb begin
        step_pos_s = pos_r;
        step_dir_s = dir_up_r;
        wrap_s     = 1'b0;
        case (mode_r)
            MODE_RIGHT: begin
                if (pos_r == POS_ZERO) begin
                    step_pos_s = MAXP;
                    wrap_s     = 1'b1;
                end else begin
                    step_pos_s = pos_r - POS_W'(1);
                end
            end
            MODE_BOUNCE: begin
                if (MAXP == POS_ZERO) begin
                    wrap_s = 1'b1;
                end else if (dir_up_r && (pos_r != MAXP)) begin
                    step_pos_s = pos_r + POS_W'(1);
                end else begin
                    // Moving down (including the turnaround at MAXP); landing on 0 ends the pass.
                    step_pos_s = pos_r - POS_W'(1);
                    if (step_pos_s == POS_ZERO) begin
                        wrap_s     = 1'b1;
                        step_dir_s = 1'b1;
                    end else begin
                        step_dir_s = 1'b0;
                    end
                end
            end
            default: begin
                if (pos_r == MAXP) begin
                    step_pos_s = POS_ZERO;
                    wrap_s     = 1'b1;
                end else begin
                    step_pos_s = pos_r + POS_W'(1);
                end
            end
        endcase
    end

    // Chaser FSM next-state and next-output logic; run=0 outranks any tick.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        passes_s   = passes_r;
        pass_cnt_s = pass_cnt_r;
        pos_s      = pos_r;
        dir_up_s   = dir_up_r;
        pulse_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.run) begin
                    mode_s     = decode_mode(bus.mode);
                    passes_s   = bus.passes;
                    pos_s      = home_pos(decode_mode(bus.mode));
                    dir_up_s   = 1'b1;
                    pass_cnt_s = {PASS_W{1'b0}};
                    state_s    = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.run) begin
                    state_s = ST_IDLE;
                end else if (tick_s) begin
                    pos_s    = step_pos_s;
                    dir_up_s = step_dir_s;
                    if (wrap_s) begin
                        pulse_s = 1'b1;
                        if ((passes_r != {PASS_W{1'b0}}) && (pass_inc_s == passes_r)) begin
                            state_s  = ST_DONE;
                            pos_s    = home_pos(mode_r);
                            dir_up_s = 1'b1;
                        end else begin
                            pass_cnt_s = pass_inc_s;
                        end
                    end else begin
                        pulse_s = 1'b0;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!bus.run) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (state_s == ST_IDLE) begin
            out_s = {N_LEDS{1'b0}};
        end else begin
            out_s = win_pattern(pos_s);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge async_rs_n) begin
        if (!async_rs_n) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_LEFT;
            passes_r   <= {PASS_W{1'b0}};
            pass_cnt_r <= {PASS_W{1'b0}};
            pos_r      <= POS_ZERO;
            dir_up_r   <= 1'b1;
            out_r      <= {N_LEDS{1'b0}};
            pulse_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            passes_r   <= passes_s;
            pass_cnt_r <= pass_cnt_s;
            pos_r      <= pos_s;
            dir_up_r   <= dir_up_s;
            out_r      <= out_s;
            pulse_r    <= pulse_s;
            busy_r     <= (state_s == ST_RUN);
            done_r     <= (state_s == ST_DONE);
        end
    end

    assign bus.out        = out_r;
    assign bus.busy       = busy_r;
    assign bus.pass_pulse = pulse_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_led_chaser_n.sv
// Directed bench for led_chaser_n: expected {out,busy,pass_pulse,done} vectors
// are queued when stimulus is applied and compared after each clock edge.
module tb_led_chaser_n;
    logic clk = 1'b0;
    logic async_rs_n;

    always #5 clk = ~clk;

    led_chaser_n_if #(.N_LEDS(18), .DIV_W(8), .PASS_W(4)) bus  ();
    led_chaser_n_if #(.N_LEDS(4),  .DIV_W(8), .PASS_W(4)) bus4 ();

    led_chaser_n #(.N_LEDS(18), .WIN(3), .DIV_W(8), .PASS_W(4)) dut (
        .clk        (clk),
        .async_rs_n (async_rs_n),
        .bus        (bus.slave)
    );

    led_chaser_n #(.N_LEDS(4), .WIN(4), .DIV_W(8), .PASS_W(4)) dut4 (
        .clk        (clk),
        .async_rs_n (async_rs_n),
        .bus        (bus4.slave)
    );

    typedef struct {
        string       tag;
        int          which;
        logic [20:0] vec;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [20:0] observe(input int which);
        if (which == 0) return {bus.out, bus.busy, bus.pass_pulse, bus.done};
        else            return {14'd0, bus4.out, bus4.busy, bus4.pass_pulse, bus4.done};
    endfunction

    task automatic push_exp(input string tag, input int which, input logic [17:0] eo, input logic [2:0] fl);
        exp_t e;
        e.tag   = tag;
        e.which = which;
        e.vec   = {eo, fl};
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t        e;
        logic [20:0] o;
        e = sb.pop_front();
        o = observe(e.which);
        vectors++;
        assert (o === e.vec) else begin
            miscompares++;
            $error("FAIL %s: observed out=%h bpd=%b expected out=%h bpd=%b",
                   e.tag, o[20:3], o[2:0], e.vec[20:3], e.vec[2:0]);
        end
    endtask

    // fl = {busy, pass_pulse, done}
    task automatic cyc(input string tag, input int which, input logic [17:0] eo, input logic [2:0] fl);
        push_exp(tag, which, eo, fl);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic now(input string tag, input int which, input logic [17:0] eo, input logic [2:0] fl);
        push_exp(tag, which, eo, fl);
        compare_head();
    endtask

    initial begin
        async_rs_n    = 1'b0;
        bus.run       = 1'b0;  bus.step_en  = 1'b1; bus.mode  = 2'd0;
        bus.step_div  = 8'd0;  bus.passes   = 4'd0;
        bus4.run      = 1'b0;  bus4.step_en = 1'b1; bus4.mode = 2'd0;
        bus4.step_div = 8'd0;  bus4.passes  = 4'd0;
        #12;
        now("reset_main", 0, 18'h0, 3'b000);
        now("reset_small", 1, 18'h0, 3'b000);
        @(posedge clk); #1;
        async_rs_n = 1'b1;
        cyc("idle", 0, 18'h0, 3'b000);

        // 1: LEFT, every cycle a tick, single pass
        bus.mode = 2'd0; bus.step_div = 8'd0; bus.passes = 4'd1; bus.run = 1'b1;
        for (int c = 1; c <= 16; c++) cyc("t1_walk", 0, 18'h7 << (c - 1), 3'b100);
        cyc("t1_done", 0, 18'h00007, 3'b011);
        cyc("t1_hold", 0, 18'h00007, 3'b001);
        bus.run = 1'b0;
        cyc("t1_idle", 0, 18'h0, 3'b000);

        // 2: RIGHT, 3 clocks per step, two passes 48 clocks apart
        bus.mode = 2'd1; bus.step_div = 8'd2; bus.passes = 4'd2; bus.run = 1'b1;
        for (int c = 1; c <= 96; c++) begin
            int idx;
            idx = (c <= 48) ? (c - 1) : (c - 49);
            cyc("t2_walk", 0, 18'h7 << (15 - idx / 3), (c == 49) ? 3'b110 : 3'b100);
        end
        cyc("t2_done", 0, 18'h38000, 3'b011);
        cyc("t2_hold", 0, 18'h38000, 3'b001);
        bus.run = 1'b0;
        cyc("t2_idle", 0, 18'h0, 3'b000);

        // 3: BOUNCE, far endpoint shown once, pass on return home
        bus.mode = 2'd2; bus.step_div = 8'd0; bus.passes = 4'd1; bus.run = 1'b1;
        for (int c = 1; c <= 16; c++) cyc("t3_up", 0, 18'h7 << (c - 1), 3'b100);
        for (int c = 17; c <= 30; c++) cyc("t3_down", 0, 18'h7 << (31 - c), 3'b100);
        cyc("t3_done", 0, 18'h00007, 3'b011);
        bus.run = 1'b0;
        cyc("t3_idle", 0, 18'h0, 3'b000);

        // 4a: pause keeps position and prescaler phase
        bus.mode = 2'd0; bus.step_div = 8'd1; bus.passes = 4'd0; bus.run = 1'b1;
        cyc("t4_p0a", 0, 18'h00007, 3'b100);
        cyc("t4_p0b", 0, 18'h00007, 3'b100);
        cyc("t4_p1a", 0, 18'h0000E, 3'b100);
        cyc("t4_p1b", 0, 18'h0000E, 3'b100);
        bus.step_en = 1'b0;
        for (int c = 0; c < 10; c++) cyc("t4_pause", 0, 18'h0000E, 3'b100);
        bus.step_en = 1'b1;
        cyc("t4_resume", 0, 18'h0001C, 3'b100);
        cyc("t4_p2b", 0, 18'h0001C, 3'b100);
        cyc("t4_p3a", 0, 18'h00038, 3'b100);
        bus.run = 1'b0;
        cyc("t4_idle", 0, 18'h0, 3'b000);

        // 4b: endless passes, then abort on the pass tick
        bus.step_div = 8'd0; bus.passes = 4'd0; bus.run = 1'b1;
        for (int c = 1; c <= 16; c++) cyc("t4_walk", 0, 18'h7 << (c - 1), 3'b100);
        cyc("t4_wrap", 0, 18'h00007, 3'b110);
        for (int c = 18; c <= 32; c++) cyc("t4_walk2", 0, 18'h7 << (c - 17), 3'b100);
        bus.run = 1'b0;
        cyc("t4_abort", 0, 18'h0, 3'b000);
        cyc("t4_nopulse", 0, 18'h0, 3'b000);

        // 5: reserved mode runs LEFT, mode change ignored, async reset mid-run
        bus.mode = 2'd3; bus.passes = 4'd0; bus.run = 1'b1;
        for (int c = 1; c <= 4; c++) cyc("t5_left", 0, 18'h7 << (c - 1), 3'b100);
        bus.mode = 2'd1;
        for (int c = 5; c <= 8; c++) cyc("t5_latched", 0, 18'h7 << (c - 1), 3'b100);
        #1;
        async_rs_n = 1'b0;
        #1;
        now("t5_async_rst", 0, 18'h0, 3'b000);
        cyc("t5_rst_held", 0, 18'h0, 3'b000);
        bus.run = 1'b0;
        async_rs_n = 1'b1;
        cyc("t5_idle", 0, 18'h0, 3'b000);

        // 6: full-width window, every tick completes a pass
        bus4.mode = 2'd0; bus4.step_div = 8'd0; bus4.passes = 4'd3; bus4.run = 1'b1;
        cyc("t6_home", 1, 18'h0000F, 3'b100);
        cyc("t6_pass1", 1, 18'h0000F, 3'b110);
        cyc("t6_pass2", 1, 18'h0000F, 3'b110);
        cyc("t6_done", 1, 18'h0000F, 3'b011);
        cyc("t6_hold", 1, 18'h0000F, 3'b001);
        bus4.run = 1'b0;
        cyc("t6_idle", 1, 18'h0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
